// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared state encoding and byte width for the CRC frame sequencer
package crc_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT    = 3'd2,
    SHIFT   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/crc_frame_sequencer_if.sv
// rtl/crc_frame_sequencer_if.sv - byte input stream and CRC result stream of the sequencer
interface crc_frame_sequencer_if #(
  parameter int WIDTH = 64
);
  import crc_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              crc_valid;
  logic              crc_ready;
  logic [WIDTH-1:0]  crc_value;

  modport master (
    output in_valid, in_data, in_last, crc_ready,
    input  in_ready, crc_valid, crc_value
  );

  modport slave (
    input  in_valid, in_data, in_last, crc_ready,
    output in_ready, crc_valid, crc_value
  );

endinterface

// File: rtl/crc_bit_serializer.sv
// rtl/crc_bit_serializer.sv - latches one byte and presents it as a registered serial bit stream
module crc_bit_serializer
  import crc_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              advance,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data,
  output logic              serial,
  output logic              done
);

  logic [BYTE_W-1:0] byte_q;
  logic [2:0]        cnt_q;
  logic              serial_q;

  function automatic logic pick(input logic [BYTE_W-1:0] b, input logic [2:0] k);
    return LSB_FIRST ? b[k] : b[3'd7 - k];
  endfunction

  assign done   = (cnt_q == 3'd7);
  assign serial = serial_q;

  // serial_q always holds bit[cnt_q], so the pin is a flop output aligned with the shift strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q   <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
    end else if (clear) begin
      cnt_q    <= '0;
      serial_q <= 1'b0;
    end else if (load) begin
      byte_q   <= data;
      cnt_q    <= '0;
      serial_q <= pick(data, 3'd0);
    end else if (advance) begin
      cnt_q    <= cnt_q + 3'd1;
      serial_q <= done ? 1'b0 : pick(byte_q, cnt_q + 3'd1);
    end
  end

endmodule

// File: rtl/lfsrN.sv
// rtl/lfsrN.sv - Galois CRC shift register, MSB out, one serial bit per shift
module lfsrN #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             data,
  input  logic [WIDTH-1:0] taps,
  input  logic [WIDTH-1:0] init_value,
  output logic [WIDTH-1:0] value
);

  logic fb;

  assign fb = value[WIDTH-1] ^ data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= init_value;
    end else if (shift) begin
      value <= {value[WIDTH-2:0], 1'b0} ^ (fb ? taps : '0);
    end
  end

endmodule

// File: rtl/crc_frame_sequencer.sv
// rtl/crc_frame_sequencer.sv - drives an lfsrN instance bit-serially over a byte frame and returns the final CRC
module crc_frame_sequencer
  import crc_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter bit LSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     cfg_taps,
  input  logic [WIDTH-1:0]     cfg_init,
  input  logic [WIDTH-1:0]     cfg_xorout,
  input  logic                 start,
  input  logic                 abort,
  crc_frame_sequencer_if.slave bus,
  output logic                 lfsr_load,
  output logic                 lfsr_shift,
  output logic                 lfsr_data,
  output logic [WIDTH-1:0]     lfsr_taps,
  output logic [WIDTH-1:0]     lfsr_init,
  input  logic [WIDTH-1:0]     lfsr_value,
  output logic [CNT_W-1:0]     byte_count,
  output logic                 busy
);

  state_t           state_q, state_d;
  logic             in_ready_q, load_q, shift_q, crc_valid_q, busy_q;
  logic             in_ready_d, load_d, shift_d, crc_valid_d, busy_d;
  logic             last_q;
  logic [WIDTH-1:0] crc_q;
  logic [CNT_W-1:0] count_q;
  logic             accept, frame_start, shift_done;

  assign accept      = (state_q == WAIT) && bus.in_valid && in_ready_q && !abort;
  assign frame_start = start && ((state_q == IDLE) || ((state_q == DONE) && bus.crc_ready));

  crc_bit_serializer #(
    .LSB_FIRST (LSB_FIRST)
  ) u_serializer (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .advance ((state_q == SHIFT) && !abort),
    .clear   (abort),
    .data    (bus.in_data),
    .serial  (lfsr_data),
    .done    (shift_done)
  );

  // Strobes are registered decodes of the next state, so each pin is high exactly while its state is current
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      load_q      <= 1'b0;
      shift_q     <= 1'b0;
      crc_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      load_q      <= load_d;
      shift_q     <= shift_d;
      crc_valid_q <= crc_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = LOAD;
        LOAD:    state_d = WAIT;
        WAIT:    if (accept) state_d = SHIFT;
        SHIFT:   if (shift_done) state_d = last_q ? CAPTURE : WAIT;
        CAPTURE: state_d = DONE;
        DONE:    if (bus.crc_ready) state_d = start ? LOAD : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_d  = (state_d == WAIT);
    load_d      = (state_d == LOAD);
    shift_d     = (state_d == SHIFT);
    crc_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      last_q  <= 1'b0;
      crc_q   <= '0;
    end else if (!abort) begin
      if (frame_start) begin
        count_q <= '0;
      end else if (accept && (count_q != {CNT_W{1'b1}})) begin
        count_q <= count_q + CNT_W'(1);
      end
      if (accept) begin
        last_q <= bus.in_last;
      end
      if (state_q == CAPTURE) begin
        crc_q <= lfsr_value ^ cfg_xorout;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.crc_valid = crc_valid_q;
  assign bus.crc_value = crc_q;
  assign lfsr_load     = load_q;
  assign lfsr_shift    = shift_q;
  assign lfsr_taps     = cfg_taps;
  assign lfsr_init     = cfg_init;
  assign byte_count    = count_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_crc_frame_sequencer.sv
// tb/tb_crc_frame_sequencer.sv - LSB-first and MSB-first sequencers driven in lockstep against a bit-serial model
module tb_crc_frame_sequencer;

  localparam int W  = 32;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] cfg_taps, cfg_init, cfg_xorout;
  logic         start, abort, in_valid, in_last, crc_ready;
  logic [7:0]   in_data;

  crc_frame_sequencer_if #(.WIDTH(W)) bus_l ();
  crc_frame_sequencer_if #(.WIDTH(W)) bus_m ();

  assign bus_l.in_valid  = in_valid;
  assign bus_l.in_data   = in_data;
  assign bus_l.in_last   = in_last;
  assign bus_l.crc_ready = crc_ready;
  assign bus_m.in_valid  = in_valid;
  assign bus_m.in_data   = in_data;
  assign bus_m.in_last   = in_last;
  assign bus_m.crc_ready = crc_ready;

  logic          load_l, shift_l, data_l, busy_l;
  logic          load_m, shift_m, data_m, busy_m;
  logic [W-1:0]  taps_l, init_l, value_l, taps_m, init_m, value_m;
  logic [CW-1:0] cnt_l, cnt_m;

  crc_frame_sequencer #(.WIDTH(W), .LSB_FIRST(1'b1), .CNT_W(CW)) u_dut_lsb (
    .clk(clk), .rst(rst), .cfg_taps(cfg_taps), .cfg_init(cfg_init), .cfg_xorout(cfg_xorout),
    .start(start), .abort(abort), .bus(bus_l), .lfsr_load(load_l), .lfsr_shift(shift_l),
    .lfsr_data(data_l), .lfsr_taps(taps_l), .lfsr_init(init_l), .lfsr_value(value_l),
    .byte_count(cnt_l), .busy(busy_l)
  );
  lfsrN #(.WIDTH(W)) u_lfsr_lsb (
    .clk(clk), .rst(rst), .load(load_l), .shift(shift_l), .data(data_l),
    .taps(taps_l), .init_value(init_l), .value(value_l)
  );

  crc_frame_sequencer #(.WIDTH(W), .LSB_FIRST(1'b0), .CNT_W(CW)) u_dut_msb (
    .clk(clk), .rst(rst), .cfg_taps(cfg_taps), .cfg_init(cfg_init), .cfg_xorout(cfg_xorout),
    .start(start), .abort(abort), .bus(bus_m), .lfsr_load(load_m), .lfsr_shift(shift_m),
    .lfsr_data(data_m), .lfsr_taps(taps_m), .lfsr_init(init_m), .lfsr_value(value_m),
    .byte_count(cnt_m), .busy(busy_m)
  );
  lfsrN #(.WIDTH(W)) u_lfsr_msb (
    .clk(clk), .rst(rst), .load(load_m), .shift(shift_m), .data(data_m),
    .taps(taps_m), .init_value(init_m), .value(value_m)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] frame [0:15];
  bit         bits_l[$];
  bit         bits_m[$];
  int         ready_cyc[$];
  int         load_cyc, valid_cyc, last_shift_cyc;
  bit         got_valid;

  function automatic logic [W-1:0] model_crc(input int n, input bit lsb);
    logic [W-1:0] c;
    logic [7:0]   b;
    logic         fb;
    c = cfg_init;
    for (int i = 0; i < n; i++) begin
      b = frame[i];
      for (int k = 0; k < 8; k++) begin
        fb = c[W-1] ^ (lsb ? b[k] : b[7-k]);
        c  = {c[W-2:0], 1'b0} ^ (fb ? cfg_taps : '0);
      end
    end
    return c ^ cfg_xorout;
  endfunction

  // First serial bit lands in the MSB so the result reads left to right in shift order
  function automatic logic [7:0] seq(input bit msb_inst, input int base);
    logic [7:0] s;
    for (int k = 0; k < 8; k++) s[7-k] = msb_inst ? bits_m[base+k] : bits_l[base+k];
    return s;
  endfunction

  task automatic run_frame(input int n, input int abort_at);
    int idx, cyc, nshift;
    bit pend;
    idx = 0; cyc = 0; nshift = 0; pend = 1'b0;
    got_valid = 1'b0; load_cyc = -1; valid_cyc = -1; last_shift_cyc = -1;
    bits_l.delete(); bits_m.delete(); ready_cyc.delete();
    in_valid = 1'b1; in_data = frame[0]; in_last = (n == 1);
    while (cyc < 400) begin
      @(negedge clk);
      start = 1'b0; crc_ready = 1'b0;
      if (pend) begin
        pend = 1'b0;
        idx++;
        if (idx < n) begin
          in_data = frame[idx]; in_last = (idx == n - 1);
        end else begin
          in_valid = 1'b0; in_last = 1'b0;
        end
      end
      if (load_l && load_cyc < 0) load_cyc = cyc;
      if (shift_l) begin
        bits_l.push_back(data_l); bits_m.push_back(data_m);
        nshift++; last_shift_cyc = cyc;
      end
      if (bus_l.crc_valid) begin got_valid = 1'b1; valid_cyc = cyc; break; end
      if (abort_at >= 0 && nshift == abort_at) begin abort = 1'b1; break; end
      if (bus_l.in_ready) ready_cyc.push_back(cyc);
      if (bus_l.in_ready && in_valid) pend = 1'b1;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    if (abort_at < 0) begin
      checks++;
      if (!got_valid) begin errors++; $display("FAIL frame_done: no crc_valid within %0d cycles", cyc); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
    abort = 1'b0; crc_ready = 1'b0;
    cfg_taps = 32'h04C1_1DB7; cfg_init = 32'hFFFF_FFFF; cfg_xorout = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({load_l, shift_l, data_l, bus_l.in_ready, bus_l.crc_valid, busy_l,
         load_m, shift_m, data_m, bus_m.in_ready, bus_m.crc_valid, busy_m} !== 12'h000) begin
      errors++; $display("FAIL reset_strobes: got %b/%b required all 0",
        {load_l, shift_l, data_l, bus_l.in_ready, bus_l.crc_valid, busy_l},
        {load_m, shift_m, data_m, bus_m.in_ready, bus_m.crc_valid, busy_m});
    end
    checks++;
    if (bus_l.crc_value !== 32'h0 || bus_m.crc_value !== 32'h0 || cnt_l !== 16'h0 || cnt_m !== 16'h0) begin
      errors++; $display("FAIL reset_values: crc %h/%h count %0d/%0d required 0",
        bus_l.crc_value, bus_m.crc_value, cnt_l, cnt_m);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (load_l !== 1'b1 || load_m !== 1'b1 || shift_l !== 1'b0) begin
      errors++; $display("FAIL reset_load_pulse: load %b/%b shift %b required 1/1/0", load_l, load_m, shift_l);
    end
    start = 1'b0; in_valid = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy_l !== 1'b0 || busy_m !== 1'b0 || load_l !== 1'b0 || bus_l.in_ready !== 1'b0) begin
      errors++; $display("FAIL abort_in_load: busy %b/%b load %b ready %b required 0", busy_l, busy_m, load_l, bus_l.in_ready);
    end
  endtask

  task automatic test_single_byte;
    logic [W-1:0] exp_l, exp_m;
    cfg_xorout = 32'h0; frame[0] = 8'hA5;
    exp_l = model_crc(1, 1'b1); exp_m = model_crc(1, 1'b0);
    @(negedge clk); start = 1'b1;
    run_frame(1, -1);
    checks++;
    if (bits_l.size() != 8 || seq(1'b0, 0) !== 8'b1010_0101 || seq(1'b1, 0) !== 8'b1010_0101) begin
      errors++; $display("FAIL a5_bits: n=%0d lsb %b msb %b required 8 bits 10100101", bits_l.size(), seq(1'b0, 0), seq(1'b1, 0));
    end
    checks++;
    if (valid_cyc - last_shift_cyc != 2) begin
      errors++; $display("FAIL a5_valid_latency: got %0d required 2", valid_cyc - last_shift_cyc);
    end
    checks++;
    if (cnt_l !== 16'd1 || cnt_m !== 16'd1) begin
      errors++; $display("FAIL a5_count: got %0d/%0d required 1", cnt_l, cnt_m);
    end
    checks++;
    if (bus_l.crc_value !== exp_l || bus_m.crc_value !== exp_m) begin
      errors++; $display("FAIL a5_crc: got %h/%h required %h/%h", bus_l.crc_value, bus_m.crc_value, exp_l, exp_m);
    end
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
    checks++;
    if (busy_l !== 1'b0 || bus_l.crc_valid !== 1'b0 || bus_m.crc_valid !== 1'b0) begin
      errors++; $display("FAIL a5_release: busy %b valid %b/%b required 0", busy_l, bus_l.crc_valid, bus_m.crc_valid);
    end
  endtask

  task automatic test_bit_order;
    logic [W-1:0] exp_l, exp_m;
    cfg_xorout = 32'hFFFF_FFFF; frame[0] = 8'h0F;
    exp_l = model_crc(1, 1'b1); exp_m = model_crc(1, 1'b0);
    @(negedge clk); start = 1'b1;
    run_frame(1, -1);
    checks++;
    if (seq(1'b0, 0) !== 8'b1111_0000) begin
      errors++; $display("FAIL 0f_bits_lsb: got %b required 11110000", seq(1'b0, 0));
    end
    checks++;
    if (seq(1'b1, 0) !== 8'b0000_1111) begin
      errors++; $display("FAIL 0f_bits_msb: got %b required 00001111", seq(1'b1, 0));
    end
    checks++;
    if (bus_l.crc_value !== exp_l || bus_m.crc_value !== exp_m) begin
      errors++; $display("FAIL 0f_crc_xorout: got %h/%h required %h/%h", bus_l.crc_value, bus_m.crc_value, exp_l, exp_m);
    end
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
  endtask

  task automatic test_stream;
    logic [W-1:0] exp_l, exp_m;
    cfg_xorout = 32'h0;
    frame[0] = 8'h12; frame[1] = 8'h34; frame[2] = 8'h56; frame[3] = 8'h78;
    exp_l = model_crc(4, 1'b1); exp_m = model_crc(4, 1'b0);
    @(negedge clk); start = 1'b1;
    run_frame(4, -1);
    checks++;
    if (ready_cyc.size() != 4) begin
      errors++; $display("FAIL stream_ready_pulses: got %0d required 4", ready_cyc.size());
    end
    for (int i = 0; i + 1 < ready_cyc.size(); i++) begin
      checks++;
      if (ready_cyc[i+1] - ready_cyc[i] != 9) begin
        errors++; $display("FAIL stream_pitch[%0d]: got %0d required 9", i, ready_cyc[i+1] - ready_cyc[i]);
      end
    end
    checks++;
    if (cnt_l !== 16'd4 || cnt_m !== 16'd4 || bits_l.size() != 32) begin
      errors++; $display("FAIL stream_count: got %0d/%0d shifts %0d required 4/4/32", cnt_l, cnt_m, bits_l.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus_l.crc_valid !== 1'b1 || bus_l.crc_value !== exp_l || bus_m.crc_value !== exp_m) begin
        errors++; $display("FAIL stream_hold[%0d]: valid %b crc %h/%h required 1 %h/%h",
          i, bus_l.crc_valid, bus_l.crc_value, bus_m.crc_value, exp_l, exp_m);
      end
      @(negedge clk);
    end
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
    checks++;
    if (bus_l.crc_valid !== 1'b0 || busy_m !== 1'b0) begin
      errors++; $display("FAIL stream_release: valid %b busy %b required 0", bus_l.crc_valid, busy_m);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] exp_l, exp_m;
    cfg_xorout = 32'hFFFF_FFFF;
    for (int i = 0; i < 9; i++) frame[i] = 8'h31 + 8'(i);
    exp_l = model_crc(9, 1'b1);
    @(negedge clk); start = 1'b1;
    run_frame(9, -1);
    checks++;
    if (bus_m.crc_value !== 32'hFC89_1918) begin
      errors++; $display("FAIL check_string_msb: got %h required fc891918", bus_m.crc_value);
    end
    checks++;
    if (bus_l.crc_value !== exp_l || cnt_l !== 16'd9) begin
      errors++; $display("FAIL check_string_lsb: got %h count %0d required %h 9", bus_l.crc_value, cnt_l, exp_l);
    end
    crc_ready = 1'b1; start = 1'b1;
    frame[0] = 8'hDE; frame[1] = 8'hAD; frame[2] = 8'hBE; frame[3] = 8'hEF;
    exp_l = model_crc(4, 1'b1); exp_m = model_crc(4, 1'b0);
    run_frame(4, -1);
    checks++;
    if (load_cyc != 0) begin
      errors++; $display("FAIL b2b_load: load seen at cycle %0d required 0", load_cyc);
    end
    checks++;
    if (bus_l.crc_value !== exp_l || bus_m.crc_value !== exp_m || cnt_m !== 16'd4) begin
      errors++; $display("FAIL b2b_crc: got %h/%h count %0d required %h/%h 4",
        bus_l.crc_value, bus_m.crc_value, cnt_m, exp_l, exp_m);
    end
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
  endtask

  task automatic test_abort;
    logic [W-1:0] exp_l, exp_m;
    int           stray;
    cfg_xorout = 32'h0;
    frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33;
    @(negedge clk); start = 1'b1;
    run_frame(3, 12);
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy_l !== 1'b0 || busy_m !== 1'b0 || shift_l !== 1'b0 || shift_m !== 1'b0 || bus_l.crc_valid !== 1'b0) begin
      errors++; $display("FAIL abort_shift_state: busy %b/%b shift %b/%b valid %b required 0",
        busy_l, busy_m, shift_l, shift_m, bus_l.crc_valid);
    end
    stray = 0;
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (shift_l || shift_m || load_l || bus_l.in_ready) stray++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if (stray != 0 || cnt_l !== 16'd2 || cnt_m !== 16'd2) begin
      errors++; $display("FAIL abort_shift_quiet: stray %0d count %0d/%0d required 0 2/2", stray, cnt_l, cnt_m);
    end
    exp_l = model_crc(3, 1'b1); exp_m = model_crc(3, 1'b0);
    @(negedge clk); start = 1'b1;
    run_frame(3, -1);
    checks++;
    if (bus_l.crc_value !== exp_l || bus_m.crc_value !== exp_m || cnt_l !== 16'd3) begin
      errors++; $display("FAIL abort_recover_crc: got %h/%h count %0d required %h/%h 3",
        bus_l.crc_value, bus_m.crc_value, cnt_l, exp_l, exp_m);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (bus_l.crc_valid !== 1'b0 || bus_m.crc_valid !== 1'b0 || busy_l !== 1'b0 ||
        bus_l.crc_value !== exp_l || bus_m.crc_value !== exp_m) begin
      errors++; $display("FAIL abort_done: valid %b/%b busy %b crc %h/%h required 0/0 0 %h/%h",
        bus_l.crc_valid, bus_m.crc_valid, busy_l, bus_l.crc_value, bus_m.crc_value, exp_l, exp_m);
    end
    cfg_xorout = 32'hFFFF_FFFF; frame[0] = 8'hC3;
    exp_l = model_crc(1, 1'b1); exp_m = model_crc(1, 1'b0);
    @(negedge clk); start = 1'b1;
    run_frame(1, -1);
    checks++;
    if (bus_l.crc_value !== exp_l || bus_m.crc_value !== exp_m || cnt_l !== 16'd1) begin
      errors++; $display("FAIL abort_done_recover: got %h/%h count %0d required %h/%h 1",
        bus_l.crc_value, bus_m.crc_value, cnt_l, exp_l, exp_m);
    end
    crc_ready = 1'b1;
    @(negedge clk);
    crc_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_bit_order();
    test_stream();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
